multiplier_controller: RTL and testbench

Control FSM for the shift-and-add sequential multiplier. It sits directly upstream of the multiplier datapath and drives that datapath's register strobes: it loads both operands, walks the multiplier bits LSB-first, and issues one conditional add plus one right shift per bit. It signals completion to the requester with a start/done handshake. The datapath's `product` is valid while `done` is high and stays valid until the next accepted `start`.

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/multiplier_controller.sv | 79 +++++++
 tb/tb_multiplier_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add sequential multiplier.
// Holds the controller state encoding and the default operand width.
package multiplier_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/multiplier_controller.sv
// Control FSM for the shift-and-add multiplier datapath.
// Loads operands, then one conditional add and one shift per bit.
module multiplier_controller
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplierReg,
  output logic             busy,
  output logic             done,
  output logic             mrld,
  output logic             mdld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  mult_state_t   state;
  mult_state_t   state_nxt;
  logic [IW-1:0] bit_idx;
  logic          load_q;
  logic          add_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (bit_idx == LAST) ? DONE : ADD;
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      rsshr   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt == LOAD) ||
                (state_nxt == ADD) ||
                (state_nxt == SHIFT);
      done   <= (state_nxt == DONE);
      load_q <= (state_nxt == LOAD);
      add_q  <= (state_nxt == ADD);
      rsshr  <= (state_nxt == SHIFT);
      unique case (1'b1)
        state == LOAD:
          bit_idx <= '0;
        state == SHIFT && bit_idx != LAST:
          bit_idx <= bit_idx + 1'b1;
        default:
          bit_idx <= bit_idx;
      endcase
    end
  end

  assign mrld    = load_q;
  assign mdld    = load_q;
  assign rsclear = load_q;

  // The multiplier register only settles after LOAD, so this stays combinational.
  assign rsload  = add_q & multiplierReg[bit_idx];

endmodule

// File: tb/tb_multiplier_controller.sv
// Bench for multiplier_controller with a behavioural datapath.
// Outputs are checked cycle by cycle against the operation timeline.
module tb_multiplier_controller;

  localparam int W = 4;
  localparam int NC = 2 * W + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] mr;
  logic         busy;
  logic         done;
  logic         mrld;
  logic         mdld;
  logic         rsclear;
  logic         rsload;
  logic         rsshr;

  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] md;
  logic [2*W:0]   rs;
  logic [2*W-1:0] product;

  int checks;
  int failures;

  multiplier_controller #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .multiplierReg (mr),
    .busy          (busy),
    .done          (done),
    .mrld          (mrld),
    .mdld          (mdld),
    .rsclear       (rsclear),
    .rsload        (rsload),
    .rsshr         (rsshr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: shift overrides add, clear overrides both.
  always @(posedge clk) begin
    if (mrld) mr <= op_a;
    if (mdld) md <= {op_b, {W{1'b0}}};
    if (rsclear) rs <= '0;
    else if (rsshr) rs <= rs >> 1;
    else if (rsload) rs <= rs + {1'b0, md};
  end

  assign product = rs[2*W-1:0];

  // Expected {busy,done,mrld,mdld,rsclear,rsload,rsshr} in cycle k after start.
  function automatic logic [6:0] expect_out(input logic [W-1:0] a,
                                            input int k);
    logic b, d, l, ad, sh;
    b  = (k >= 1) && (k <= 2 * W + 1);
    d  = (k == 2 * W + 2);
    l  = (k == 1);
    ad = 1'b0;
    if (k >= 2 && k <= 2 * W && (k % 2) == 0) ad = a[(k - 2) / 2];
    sh = (k >= 3) && (k <= 2 * W + 1) && ((k % 2) == 1);
    return {b, d, l, l, l, ad, sh};
  endfunction

  // Starts at a negedge in the cycle before the start edge; ends in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [NC:0] mask);
    logic [6:0]     want;
    logic [6:0]     got;
    logic [2*W-1:0] want_p;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= NC; k++) begin
      want = expect_out(a, k);
      got  = {busy, done, mrld, mdld, rsclear, rsload, rsshr};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL op %0dx%0d cycle %0d outputs got=%b want=%b",
                 a, b, k, got, want);
      end
      checks++;
      if ((rsload && rsshr) || (rsclear && (rsload || rsshr)) ||
          (done && busy)) begin
        failures++;
        $display("FAIL exclusive %0dx%0d cycle %0d got=%b want=no overlap",
                 a, b, k, got);
      end
      start = mask[k];
      if (k != NC) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    want_p = a * b;
    checks++;
    if (product !== want_p) begin
      failures++;
      $display("FAIL product %0dx%0d got=%0d want=%0d",
               a, b, product, want_p);
    end
  endtask

  task automatic idle_cycle(input bit chk_p, input logic [2*W-1:0] want_p);
    logic [6:0] got;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {busy, done, mrld, mdld, rsclear, rsload, rsshr};
    checks++;
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL idle outputs got=%b want=0000000", got);
    end
    if (chk_p) begin
      checks++;
      if (product !== want_p) begin
        failures++;
        $display("FAIL held_product got=%0d want=%0d", product, want_p);
      end
    end
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #3;
    got = {busy, done, mrld, mdld, rsclear, rsload, rsshr};
    checks++;
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL reset outputs got=%b want=0000000", got);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0, '0);
  endtask

  task automatic test_basic;
    run_op(4'd13, 4'd11, '0);
    idle_cycle(1'b1, 8'd143);
  endtask

  task automatic test_zero_and_max;
    run_op(4'd0, 4'd15, '0);
    idle_cycle(1'b1, 8'd0);
    run_op(4'd15, 4'd15, '0);
    idle_cycle(1'b1, 8'd225);
  endtask

  task automatic test_ignored_start;
    logic [NC:0] m;
    m = '0;
    m[3] = 1'b1;
    m[7] = 1'b1;
    run_op(4'd13, 4'd11, m);
    idle_cycle(1'b1, 8'd143);
  endtask

  task automatic test_back_to_back;
    logic [NC:0] m;
    m = '1;
    run_op(4'd3, 4'd5, m);
    m[NC] = 1'b0;
    run_op(4'd7, 4'd9, m);
    idle_cycle(1'b1, 8'd63);
  endtask

  task automatic test_reset_mid_op;
    logic [6:0] got;
    op_a  = 4'd9;
    op_b  = 4'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (!(rsshr === 1'b1 && busy === 1'b1)) begin
      failures++;
      $display("FAIL pre_reset_shift got rsshr=%b busy=%b want 1 1",
               rsshr, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {busy, done, mrld, mdld, rsclear, rsload, rsshr};
    checks++;
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL async_reset outputs got=%b want=0000000", got);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0, '0);
    run_op(4'd6, 4'd7, '0);
    idle_cycle(1'b1, 8'd42);
  endtask

  task automatic test_random;
    logic [NC:0]  m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           chained;
    chained = 1'b0;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      m = (NC + 1)'($urandom);
      m[0] = 1'b0;
      run_op(a, b, m);
      chained = m[NC];
      if (!chained) idle_cycle(1'b1, a * b);
    end
    if (chained) begin
      run_op(4'd10, 4'd12, '0);
      idle_cycle(1'b1, 8'd120);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_zero_and_max;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
